// File: rtl/writeback_queue_if.sv
// writeback_queue_if: producer, register-file and issue-stage signals of the writeback queue
interface writeback_queue_if #(parameter int DEPTH = 4);
  logic a_valid, a_ready, m_valid, m_ready, hold, write, RL_pending, RR_pending;
  logic [4:0] a_rd, m_rd, RD, RL, RR;
  logic [31:0] a_value, m_value, RDvalue;
  logic [$clog2(DEPTH):0] count;
  modport master (
    output a_valid, a_rd, a_value, m_valid, m_rd, m_value, hold, RL, RR,
    input a_ready, m_ready, RD, RDvalue, write, RL_pending, RR_pending, count
  );
  modport slave (
    input a_valid, a_rd, a_value, m_valid, m_rd, m_value, hold, RL, RR,
    output a_ready, m_ready, RD, RDvalue, write, RL_pending, RR_pending, count
  );
endinterface

// File: rtl/writeback_queue.sv
// writeback_queue: merges adder/multiplier results into one register-file write port through a FIFO
module writeback_queue #(parameter int DEPTH = 4) (
  input logic clk,
  input logic rst,
  writeback_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [4:0] rd_mem [DEPTH];
  logic [31:0] val_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, m_idx, off;
  logic [CW-1:0] cnt, space;
  logic a_acc, m_acc, pop;
  logic [DEPTH-1:0] hit_l, hit_r;
  // space comes from the registered count only, so a same-cycle drain never lets an extra entry in
  always_comb begin
    space = CW'(DEPTH) - cnt;
    bus.a_ready = space != '0;
    bus.m_ready = space >= CW'(2) || (space == CW'(1) && !bus.a_valid);
    a_acc = bus.a_valid && bus.a_ready;
    m_acc = bus.m_valid && bus.m_ready;
    pop = cnt != '0 && !bus.hold;
    m_idx = a_acc ? wr_ptr + 1'b1 : wr_ptr;
    off = '0;
    hit_l = '0;
    hit_r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off = AW'(i) - rd_ptr;
      hit_l[i] = {1'b0, off} < cnt && rd_mem[i] == bus.RL;
      hit_r[i] = {1'b0, off} < cnt && rd_mem[i] == bus.RR;
    end
    bus.RL_pending = |hit_l || (bus.write && bus.RD == bus.RL);
    bus.RR_pending = |hit_r || (bus.write && bus.RD == bus.RR);
    bus.count = cnt;
  end
  always_ff @(posedge clk) begin
    if (a_acc) begin
      rd_mem[wr_ptr] <= bus.a_rd;
      val_mem[wr_ptr] <= bus.a_value;
    end
    if (m_acc) begin
      rd_mem[m_idx] <= bus.m_rd;
      val_mem[m_idx] <= bus.m_value;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      bus.write <= 1'b0;
      bus.RD <= '0;
      bus.RDvalue <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(a_acc) + AW'(m_acc);
      cnt <= cnt + CW'(a_acc) + CW'(m_acc) - CW'(pop);
      bus.write <= pop;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        bus.RD <= rd_mem[rd_ptr];
        bus.RDvalue <= val_mem[rd_ptr];
      end
    end
  end
endmodule

// File: tb/tb_writeback_queue.sv
// tb_writeback_queue: randomized scoreboard bench with a queue-based reference model
module tb_writeback_queue;
  localparam int DEPTH = 4;
  logic clk = 0, rst = 0;
  writeback_queue_if #(.DEPTH(DEPTH)) bus ();
  writeback_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;

  int errors = 0, checks = 0;
  logic [36:0] fq[$];
  logic [36:0] sb[$];
  logic exp_write = 0;
  logic [4:0] exp_rd = 0;
  logic [31:0] exp_val = 0;

  function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", n, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (bus.write === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_write act=RD%0d exp=no_write", bus.RD);
      end else begin
        if ({bus.RD, bus.RDvalue} !== sb[0]) begin
          errors++;
          $display("FAIL sb_order act=%h exp=%h", {bus.RD, bus.RDvalue}, sb[0]);
        end
        void'(sb.pop_front());
      end
    end
  end

  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] aval,
                       input logic mv, input logic [4:0] mrd, input logic [31:0] mval,
                       input logic h, input logic r, input logic [4:0] rl, input logic [4:0] rr,
                       output logic a_took, output logic m_took);
    int sz;
    logic ea, em, pl, pr;
    @(negedge clk);
    bus.a_valid = av; bus.a_rd = ard; bus.a_value = aval;
    bus.m_valid = mv; bus.m_rd = mrd; bus.m_value = mval;
    bus.hold = h; rst = r; bus.RL = rl; bus.RR = rr;
    #1;
    sz = fq.size();
    ea = sz < DEPTH;
    em = (DEPTH - sz >= 2) || (DEPTH - sz == 1 && !av);
    pl = exp_write && exp_rd == rl;
    pr = exp_write && exp_rd == rr;
    foreach (fq[i]) begin
      pl |= fq[i][36:32] == rl;
      pr |= fq[i][36:32] == rr;
    end
    chk("a_ready", bus.a_ready, ea);
    chk("m_ready", bus.m_ready, em);
    chk("count", bus.count, sz);
    chk("write", bus.write, exp_write);
    chk("RD", bus.RD, exp_rd);
    chk("RDvalue", bus.RDvalue, exp_val);
    chk("RL_pending", bus.RL_pending, pl);
    chk("RR_pending", bus.RR_pending, pr);
    a_took = av && ea;
    m_took = mv && em;
    @(posedge clk);
    if (r) begin
      fq.delete(); sb.delete();
      exp_write = 0; exp_rd = 0; exp_val = 0;
      a_took = 0; m_took = 0;
    end else begin
      exp_write = sz > 0 && !h;
      if (exp_write) {exp_rd, exp_val} = fq.pop_front();
      if (a_took) begin fq.push_back({ard, aval}); sb.push_back({ard, aval}); end
      if (m_took) begin fq.push_back({mrd, mval}); sb.push_back({mrd, mval}); end
    end
  endtask

  task automatic idle(input int n, input logic h);
    logic x, y;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, h, 0, 7, 8, x, y);
  endtask

  initial begin
    logic x, y, pa_v, pm_v, h;
    logic [4:0] pa_rd, pm_rd;
    logic [31:0] pa_val, pm_val;
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, x, y);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, x, y);
    idle(1, 0);
    cycle(1, 3, 32'h12345678, 0, 0, 0, 0, 0, 3, 0, x, y);
    idle(3, 0);
    cycle(1, 1, 32'h11, 1, 2, 32'h22, 0, 0, 1, 2, x, y);
    idle(3, 0);
    cycle(1, 4, 32'h44, 1, 5, 32'h55, 1, 0, 4, 5, x, y);
    cycle(1, 6, 32'h66, 1, 9, 32'h99, 1, 0, 6, 9, x, y);
    cycle(1, 10, 32'haa, 0, 0, 0, 1, 0, 10, 0, x, y);
    chk("hold_full_reject", x, 0);
    idle(6, 0);
    cycle(1, 11, 32'hb1, 1, 12, 32'hc1, 1, 0, 11, 12, x, y);
    cycle(1, 13, 32'hd1, 0, 0, 0, 1, 0, 13, 0, x, y);
    cycle(1, 14, 32'he1, 1, 15, 32'hf1, 0, 0, 14, 15, x, y);
    chk("cnt3_a_acc", x, 1);
    chk("cnt3_m_stall", y, 0);
    cycle(0, 0, 0, 1, 15, 32'hf1, 0, 0, 15, 0, x, y);
    chk("cnt3_m_acc", y, 1);
    idle(6, 0);
    cycle(1, 7, 32'h77, 0, 0, 0, 1, 0, 7, 8, x, y);
    idle(2, 1);
    idle(3, 0);
    cycle(1, 16, 32'h16, 1, 17, 32'h17, 1, 0, 16, 17, x, y);
    cycle(1, 18, 32'h18, 1, 19, 32'h19, 1, 0, 18, 19, x, y);
    idle(1, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 16, 17, x, y);
    idle(4, 0);
    pa_v = 0; pm_v = 0; pa_rd = 0; pm_rd = 0; pa_val = 0; pm_val = 0;
    for (int n = 0; n < 600; n++) begin
      h = $urandom_range(0, 3) == 0;
      cycle(pa_v, pa_rd, pa_val, pm_v, pm_rd, pm_val, h, $urandom_range(0, 63) == 0,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), x, y);
      if (!pa_v || x || rst) begin
        pa_v = $urandom_range(0, 1) == 1; pa_rd = 5'($urandom_range(0, 7)); pa_val = $urandom;
      end
      if (!pm_v || y || rst) begin
        pm_v = $urandom_range(0, 1) == 1; pm_rd = 5'($urandom_range(0, 7)); pm_val = $urandom;
      end
    end
    idle(DEPTH + 3, 0);
    chk("drain_fifo_empty", bus.count, 0);
    chk("drain_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
